pipe_adder_sub: RTL and testbench

//  Parametrised, pipelined add/subtract unit for the MIPS pipeline datapath; successor to the single-cycle 32-bit adder.

---
 rtl/pipe_adder_pkg.sv | 19 +
 rtl/adder_slice.sv | 26 ++
 rtl/pipe_adder_sub.sv | 157 +++++++++++++++
 tb/tb_pipe_adder_sub.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared types and helpers for the pipelined add/subtract unit.
//   stage_ctrl_t : per-stage control bits (valid, sub, carry out of the slice)
//   slice_w()    : width of one carry-chain slice
//   MAX_STAGES   : deepest supported pipeline
package pipe_adder_pkg;

  localparam int MAX_STAGES = 8;

  typedef struct packed {
    logic valid;
    logic sub;
    logic carry;
  } stage_ctrl_t;

  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// One combinational slice of the carry chain.
//   a, b  : W-bit operand slices (b already inverted for subtraction)
//   cin   : carry from the previous slice (or the subtract carry-in)
//   sum   : W-bit slice result
//   cout  : carry out of the slice MSB
//   ovf   : signed overflow if this slice holds the operand MSB
module adder_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  logic [W:0] total_s;

  assign total_s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign sum     = total_s[W-1:0];
  assign cout    = total_s[W];
  // Overflow: operands agree in sign but the result sign differs.
  assign ovf     = (a[W-1] == b[W-1]) & (total_s[W-1] != a[W-1]);

endmodule

// File: rtl/pipe_adder_sub.sv
// Pipelined add/subtract unit with valid/ready handshake.
// The carry chain is cut into STAGES equal slices with one register stage
// per slice, giving a latency of STAGES cycles and one beat per cycle.
// Optional feature: define PIPE_ADDER_SAT_EN to saturate the sum on signed
// overflow (carry_o/ovf_o unaffected).
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-low reset
//   flush_i      synchronous squash of all in-flight beats
//   in_valid_i   operand beat valid       in_ready_o  unit accepts a beat
//   src1_i       operand A                src2_i      operand B
//   sub_i        0: A+B, 1: A-B
//   out_valid_o  result beat valid        out_ready_i consumer accepts
//   sum_o        result                   carry_o     unsigned carry-out
//   ovf_o        signed overflow
module pipe_adder_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             ovf_o
);

  import pipe_adder_pkg::*;

  localparam int SW = slice_w(WIDTH, STAGES);

  if ((STAGES < 1) || (STAGES > MAX_STAGES) || ((WIDTH % STAGES) != 0)) begin : g_cfg_check
    $error("pipe_adder_sub: STAGES must be 1..8 and divide WIDTH");
  end

  // Stage record: control bits, sum bits produced so far, and the operand
  // bits still waiting for later slices (carried whole for simplicity).
  typedef struct packed {
    stage_ctrl_t      ctrl;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  localparam stage_t STAGE_ZERO = stage_t'({$bits(stage_t){1'b0}});

  stage_t                   stage_r [STAGES];
  stage_t                   src_s   [STAGES];
  stage_t                   nxt_s   [STAGES];
  logic [STAGES-1:0][SW-1:0] a_sl_s;
  logic [STAGES-1:0][SW-1:0] b_sl_s;
  logic [STAGES-1:0][SW-1:0] sum_sl_s;
  logic [STAGES-1:0]         cin_s;
  logic [STAGES-1:0]         cout_s;
  logic [STAGES-1:0]         ovf_s;
  logic                      adv_s;
  logic                      ovf_r;
  logic                      unused_s;

  // The whole pipe moves together; it may move whenever the output slot
  // is empty or being drained this cycle.
  assign adv_s      = out_ready_i | ~stage_r[STAGES-1].ctrl.valid;
  assign in_ready_o = adv_s;

  // Build each slice's source record and extract its operand slice.
  always_comb begin
    src_s[0].ctrl.valid = in_valid_i;
    src_s[0].ctrl.sub   = sub_i;
    src_s[0].ctrl.carry = sub_i;
    src_s[0].sum        = {WIDTH{1'b0}};
    src_s[0].a          = src1_i;
    src_s[0].b          = sub_i ? ~src2_i : src2_i;
    for (int k = 1; k < STAGES; k++) begin
      src_s[k] = stage_r[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      a_sl_s[k] = src_s[k].a[k*SW +: SW];
      b_sl_s[k] = src_s[k].b[k*SW +: SW];
      cin_s[k]  = src_s[k].ctrl.carry;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    adder_slice #(.W(SW)) u_slice (
      .a    (a_sl_s[k]),
      .b    (b_sl_s[k]),
      .cin  (cin_s[k]),
      .sum  (sum_sl_s[k]),
      .cout (cout_s[k]),
      .ovf  (ovf_s[k])
    );
  end

  // Merge each slice result into its record; the slice position in the
  // incoming partial sum is always zero, so OR-ing places it.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      nxt_s[k]            = src_s[k];
      nxt_s[k].ctrl.carry = cout_s[k];
      nxt_s[k].sum        = src_s[k].sum | (WIDTH'(sum_sl_s[k]) << (k*SW));
    end
`ifdef PIPE_ADDER_SAT_EN
    if (ovf_s[STAGES-1]) begin
      nxt_s[STAGES-1].sum = src_s[STAGES-1].a[WIDTH-1] ?
                            {1'b1, {(WIDTH-1){1'b0}}} :
                            {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      nxt_s[STAGES-1].sum = src_s[STAGES-1].sum |
                            (WIDTH'(sum_sl_s[STAGES-1]) << ((STAGES-1)*SW));
    end
`endif
  end

  // Stage registers: flush beats stall, stall holds everything, data only
  // loads for valid beats so idle stages keep their last contents.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_r[k] <= STAGE_ZERO;
      end
      ovf_r <= 1'b0;
    end else if (flush_i) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_r[k].ctrl.valid <= 1'b0;
      end
    end else if (adv_s) begin
      for (int k = 0; k < STAGES; k++) begin
        if (nxt_s[k].ctrl.valid) begin
          stage_r[k] <= nxt_s[k];
        end else begin
          stage_r[k].ctrl.valid <= 1'b0;
        end
      end
      if (nxt_s[STAGES-1].ctrl.valid) begin
        ovf_r <= ovf_s[STAGES-1];
      end
    end
  end

  assign out_valid_o = stage_r[STAGES-1].ctrl.valid;
  assign sum_o       = stage_r[STAGES-1].sum;
  assign carry_o     = stage_r[STAGES-1].ctrl.carry;
  assign ovf_o       = ovf_r;

  // Operand leftovers in the last stage and intermediate-slice overflow
  // flags have no consumer.
  assign unused_s = ^{stage_r[STAGES-1].a, stage_r[STAGES-1].b,
                      stage_r[STAGES-1].ctrl.sub, ovf_s};

endmodule

// File: tb/tb_pipe_adder_sub.sv
// Directed self-checking bench for pipe_adder_sub (WIDTH=32, STAGES=2).
// Honours PIPE_ADDER_SAT_EN for the saturated expectations.
module tb_pipe_adder_sub;

  localparam int WIDTH  = 32;
  localparam int STAGES = 2;

`ifdef PIPE_ADDER_SAT_EN
  localparam logic [31:0] EXP_OVF_ADD = 32'h7FFF_FFFF;
  localparam logic [31:0] EXP_OVF_SUB = 32'h8000_0000;
  localparam logic [31:0] EXP_OVF_NEG = 32'h8000_0000;
`else
  localparam logic [31:0] EXP_OVF_ADD = 32'h8000_0000;
  localparam logic [31:0] EXP_OVF_SUB = 32'h7FFF_FFFF;
  localparam logic [31:0] EXP_OVF_NEG = 32'h0000_0000;
`endif

  logic             clk;
  logic             rst_i;
  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             sub_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] sum_o;
  logic             carry_o;
  logic             ovf_o;

  int check_cnt;
  int error_cnt;

  // Stream vectors with hand-computed results (none overflow).
  logic [31:0] st_a   [8] = '{32'h0000_0010, 32'h0000_0100, 32'h0000_FFFF, 32'h1234_5678,
                              32'h0001_0000, 32'hDEAD_BEEF, 32'h0000_0000, 32'hCAFE_0000};
  logic [31:0] st_b   [8] = '{32'h0000_0001, 32'h0000_0010, 32'h0000_0002, 32'h1111_1111,
                              32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_BABE};
  logic        st_sub [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] st_exp [8] = '{32'h0000_0011, 32'h0000_00F0, 32'h0001_0001, 32'h2345_6789,
                              32'h0000_FFFF, 32'hDEAD_BEF0, 32'hFFFF_FFFF, 32'hCAFE_BABE};

  pipe_adder_sub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .src1_i      (src1_i),
    .src2_i      (src2_i),
    .sub_i       (sub_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .sum_o       (sum_o),
    .carry_o     (carry_o),
    .ovf_o       (ovf_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      error_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One isolated beat: check latency and the result fields.
  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [31:0] es, input logic ec, input logic eo);
    @(negedge clk);
    in_valid_i  = 1'b1;
    src1_i      = a;
    src2_i      = b;
    sub_i       = sub;
    out_ready_i = 1'b1;
    @(negedge clk);
    in_valid_i = 1'b0;
    for (int i = 1; i < STAGES; i++) begin
      check_val({tag, "_early"}, {31'd0, out_valid_o}, 32'd0);
      @(negedge clk);
    end
    check_val({tag, "_valid"}, {31'd0, out_valid_o}, 32'd1);
    check_val({tag, "_sum"},   sum_o,                es);
    check_val({tag, "_carry"}, {31'd0, carry_o},     {31'd0, ec});
    check_val({tag, "_ovf"},   {31'd0, ovf_o},       {31'd0, eo});
  endtask

  initial begin
    int sent;
    int got;
    int cyc;
    logic [31:0] exp_q [$];

    clk         = 1'b0;
    rst_i       = 1'b0;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    src1_i      = 32'd0;
    src2_i      = 32'd0;
    sub_i       = 1'b0;
    out_ready_i = 1'b1;
    check_cnt   = 0;
    error_cnt   = 0;

    // Reset state
    #2;
    check_val("rst_valid", {31'd0, out_valid_o}, 32'd0);
    check_val("rst_sum",   sum_o,                32'd0);
    check_val("rst_carry", {31'd0, carry_o},     32'd0);
    check_val("rst_ovf",   {31'd0, ovf_o},       32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    check_val("rst_ready", {31'd0, in_ready_o}, 32'd1);

    // Single-beat arithmetic vectors
    run_one("cross_carry", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
    run_one("ovf_add",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, EXP_OVF_ADD,   1'b0, 1'b1);
    run_one("sub_neg",     32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_one("ovf_sub",     32'h8000_0000, 32'h0000_0001, 1'b1, EXP_OVF_SUB,   1'b1, 1'b1);
    run_one("wrap",        32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_one("sub_pos",     32'h0000_000A, 32'h0000_0003, 1'b1, 32'h0000_0007, 1'b1, 1'b0);
    run_one("ovf_neg",     32'h8000_0000, 32'h8000_0000, 1'b0, EXP_OVF_NEG,   1'b1, 1'b1);

    // Back-to-back stream with a 3-cycle output stall
    sent = 0;
    got  = 0;
    cyc  = 0;
    while ((got < 8) && (cyc < 60)) begin
      @(negedge clk);
      out_ready_i = !((cyc >= 4) && (cyc < 7));
      if (sent < 8) begin
        in_valid_i = 1'b1;
        src1_i     = st_a[sent];
        src2_i     = st_b[sent];
        sub_i      = st_sub[sent];
      end else begin
        in_valid_i = 1'b0;
      end
      #1;
      if (!out_ready_i) begin
        check_val("stall_valid", {31'd0, out_valid_o}, 32'd1);
        check_val("stall_ready", {31'd0, in_ready_o},  32'd0);
      end
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          check_val("stream_extra", 32'd1, 32'd0);
        end else begin
          check_val("stream_sum", sum_o, exp_q.pop_front());
        end
        got++;
      end
      if (in_valid_i && in_ready_o) begin
        exp_q.push_back(st_exp[sent]);
        sent++;
      end
      cyc++;
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    check_val("stream_timeout", {31'd0, (cyc < 60)}, 32'd1);
    check_val("stream_count",   got,                 32'd8);
    @(negedge clk);
    check_val("stream_drained", {31'd0, out_valid_o}, 32'd0);

    // Flush: one beat in flight plus one presented with flush
    @(negedge clk);
    in_valid_i = 1'b1;
    src1_i     = 32'h0000_0001;
    src2_i     = 32'h0000_0002;
    sub_i      = 1'b0;
    @(negedge clk);
    flush_i    = 1'b1;
    src1_i     = 32'h0000_0003;
    @(negedge clk);
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_val("flush_quiet", {31'd0, out_valid_o}, 32'd0);
      @(negedge clk);
    end
    run_one("post_flush", 32'h0F0F_0F0F, 32'h1010_1010, 1'b0, 32'h1F1F_1F1F, 1'b0, 1'b0);

    // Flush wins over a stalled output
    @(negedge clk);
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    src1_i      = 32'h0000_0004;
    src2_i      = 32'h0000_0004;
    @(negedge clk);
    in_valid_i = 1'b0;
    @(negedge clk);
    check_val("hold_valid", {31'd0, out_valid_o}, 32'd1);
    check_val("hold_sum",   sum_o,                32'h0000_0008);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check_val("flush_stall", {31'd0, out_valid_o}, 32'd0);
    out_ready_i = 1'b1;

    // Asynchronous reset mid-stream
    @(negedge clk);
    in_valid_i = 1'b1;
    src1_i     = 32'h0000_0001;
    src2_i     = 32'h0000_0001;
    sub_i      = 1'b0;
    @(negedge clk);
    src1_i = 32'h0000_0002;
    @(negedge clk);
    src1_i = 32'h0000_0003;
    #1;
    check_val("pre_rst_valid", {31'd0, out_valid_o}, 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    check_val("async_rst_valid", {31'd0, out_valid_o}, 32'd0);
    check_val("async_rst_sum",   sum_o,                32'd0);
    @(negedge clk);
    in_valid_i = 1'b0;
    rst_i      = 1'b1;
    #1;
    check_val("post_rst_ready", {31'd0, in_ready_o}, 32'd1);
    run_one("post_rst", 32'h0000_0064, 32'h0000_00C8, 1'b0, 32'h0000_012C, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
    $finish;
  end

endmodule
